dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 mem_valid_M  in  1  MEM-stage instruction requests a data access.
REQ-004 ls_type_M  in  4  op: LB 0000, LH 0010, LW 0100, LBU 1000, LHU 1010, SB 0001, SH 0011, SW 0101; any other code is a nop.
REQ-005 addr_M  in  32  byte address.
REQ-006 Wdata_M  in  32  store data, LSB-justified.
REQ-007 stall_M  out  1  freeze pipeline while the access is in flight.
REQ-008 Rdata_M  out  32  load word shifted right by the byte offset, LSB-justified; feeds the load-extension stage.
REQ-009 rdata_valid_M  out  1  one-cycle pulse marking Rdata_M valid.
REQ-010 misalign_M  out  1  one-cycle misaligned-access pulse.
REQ-011 dmem_req / dmem_addr / dmem_we / dmem_wdata  out  1/32/4/32  memory request, word-aligned address, byte enables, lane-aligned data.
REQ-012 dmem_gnt / dmem_rvalid / dmem_rdata  in  1/1/32  request accepted / read data valid / read word.

Function
REQ-013 The block SHALL implement FSM states IDLE, REQ, WAIT and DONE.
REQ-014 IDLE: if mem_valid_M=1 and the op is valid, the block SHALL latch addr_M, ls_type_M and Wdata_M and go to REQ; otherwise it SHALL stay in IDLE.
REQ-015 REQ: dmem_req SHALL be 1 and held stable until dmem_gnt=1, then the FSM SHALL go to WAIT for loads and to DONE for stores.
REQ-016 WAIT: on dmem_rvalid=1 the block SHALL register dmem_rdata>>(8*offset) into Rdata_M and go to DONE; dmem_rvalid outside WAIT SHALL be ignored.
REQ-017 DONE: the block SHALL assert rdata_valid_M=1 for loads, return unconditionally to IDLE, and ignore all inputs.
REQ-018 stall_M SHALL be (IDLE and mem_valid_M and valid op) or state in {REQ, WAIT}, and SHALL be 0 in DONE.
REQ-019 With gnt and rvalid at the earliest legal cycles, load latency SHALL be 4 cycles (accept to DONE inclusive) and store latency SHALL be 3 cycles.
REQ-020 dmem_addr SHALL be {addr[31:2],2'b00}; offset is addr[1:0].
REQ-021 Store lanes: SB SHALL drive wdata={4{Wdata[7:0]}}, we=0001<<offset; SH SHALL drive {2{Wdata[15:0]}}, we=0011<<offset; SW SHALL drive Wdata, we=1111.
REQ-022 Loads SHALL drive dmem_we=0000.
REQ-023 Rdata_M SHALL hold its value between loads.
REQ-024 A nop or invalid ls_type SHALL issue no request and raise no stall.

Reset
REQ-025 rst_n=0 at an edge SHALL force IDLE; Rdata_M, rdata_valid_M, misalign_M, dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL be 0, and stall_M SHALL be 0 while rst_n=0.
REQ-026 On reset mid-access, dmem_req SHALL drop on the next cycle, and any later rvalid for the aborted access SHALL be ignored.

Configuration
REQ-027 With DMEM_MISALIGN_TRAP_EN defined, misaligned LH/LHU/SH (addr[0]=1) and LW/SW (addr[1:0]!=0) SHALL go IDLE->DONE with no request, misalign_M=1 and rdata_valid_M=0 in DONE.
REQ-028 Without DMEM_MISALIGN_TRAP_EN, the halfword offset SHALL use addr[1] only and the word offset SHALL be 0 (forced natural alignment), and misalign_M SHALL be tied 0.

Verification
REQ-029 LB, addr 0x1003, gnt at cycle 1, rvalid=1 with rdata 0xAB00_0000 at cycle 2 -> Rdata_M=0x0000_00AB, rdata_valid_M=1 at cycle 3; stall_M high at cycles 0-2.
REQ-030 SH, addr 0x2002, Wdata 0x0000_BEEF -> dmem_addr 0x2000, dmem_we 1100, dmem_wdata 0xBEEF_BEEF; DONE at cycle 2.
REQ-031 SW with gnt withheld 5 cycles -> dmem_req and all request fields stable, stall_M=1 throughout, DONE one cycle after gnt.
REQ-032 LW addr 0x3001: with DMEM_MISALIGN_TRAP_EN -> no dmem_req, misalign_M pulse at cycle 1; without the macro -> request to 0x3000 with offset 0.
REQ-033 rst_n=0 while in WAIT, then rvalid arrives -> IDLE, all outputs 0, rdata_valid_M stays 0.
REQ-034 mem_valid_M held high through DONE -> exactly one request issued per accept; ls_type 0111 -> no request, stall_M=0.

Source files
------------

// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl
//
// Purpose:
//   Data-memory access controller for the MEM stage of a pipelined core.
//   It accepts one load or store at a time, drives a request/grant memory
//   port with a word-aligned address, byte enables and lane-replicated store
//   data, and returns the load word shifted down by the byte offset
//   (LSB-justified) for the load-extension stage. The pipeline is stalled
//   while an access is in flight.
//
// Ports:
//   clk            in   1   clock, all state updates on the rising edge
//   rst_n          in   1   synchronous active-low reset
//   mem_valid_M    in   1   MEM-stage instruction wants a data access
//   ls_type_M      in   4   LB 0000, LH 0010, LW 0100, LBU 1000, LHU 1010,
//                           SB 0001, SH 0011, SW 0101, anything else = nop
//   addr_M         in  32   byte address
//   Wdata_M        in  32   store data, LSB-justified
//   stall_M        out  1   freeze the pipeline
//   Rdata_M        out 32   shifted load word, held between loads
//   rdata_valid_M  out  1   one-cycle pulse, Rdata_M is valid
//   misalign_M     out  1   one-cycle misaligned-access pulse
//   dmem_req       out  1   memory request
//   dmem_addr      out 32   word-aligned address
//   dmem_we        out  4   byte enables (0000 for loads)
//   dmem_wdata     out 32   lane-aligned store data
//   dmem_gnt       in   1   request accepted
//   dmem_rvalid    in   1   read data valid
//   dmem_rdata     in  32   read word
//
// Configuration:
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses
//                          skip the memory and pulse misalign_M. When not
//                          defined, halfword/word accesses are forced to
//                          natural alignment and misalign_M is tied low.
// ---------------------------------------------------------------------------
module dmem_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid_M,
    input  logic [3:0]  ls_type_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] Wdata_M,
    output logic        stall_M,
    output logic [31:0] Rdata_M,
    output logic        rdata_valid_M,
    output logic        misalign_M,
    output logic        dmem_req,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Decoded op: {valid, store, size[1:0]}
    function automatic logic [3:0] decode_op(input logic [3:0] t);
        logic [3:0] r;
        case (t)
            4'b0000: r = {1'b1, 1'b0, SZ_BYTE};
            4'b0010: r = {1'b1, 1'b0, SZ_HALF};
            4'b0100: r = {1'b1, 1'b0, SZ_WORD};
            4'b1000: r = {1'b1, 1'b0, SZ_BYTE};
            4'b1010: r = {1'b1, 1'b0, SZ_HALF};
            4'b0001: r = {1'b1, 1'b1, SZ_BYTE};
            4'b0011: r = {1'b1, 1'b1, SZ_HALF};
            4'b0101: r = {1'b1, 1'b1, SZ_WORD};
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [29:0] waddr_q, waddr_d;
    logic [3:0]  ls_type_q, ls_type_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  off_q, off_d;
    logic        mis_q, mis_d;
    logic [31:0] rdata_q, rdata_d;

    logic [3:0]  in_op;
    logic        in_valid;
    logic [1:0]  in_size;
    logic [1:0]  in_off;
    logic        in_mis;
    logic [3:0]  q_op;
    logic        q_store;
    logic [1:0]  q_size;

    // Decode the incoming op and work out the effective byte offset.
    // Halfwords only ever use addr[1]; words are always offset 0, so a
    // misaligned access without the trap silently becomes aligned.
    always_comb begin
        in_op    = decode_op(ls_type_M);
        in_valid = in_op[3];
        in_size  = in_op[1:0];
        case (in_size)
            SZ_BYTE: in_off = addr_M[1:0];
            SZ_HALF: in_off = {addr_M[1], 1'b0};
            default: in_off = 2'b00;
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        in_mis = ((in_size == SZ_HALF) && addr_M[0]) ||
                 ((in_size == SZ_WORD) && (addr_M[1:0] != 2'b00));
`else
        in_mis = 1'b0;
`endif
        q_op    = decode_op(ls_type_q);
        q_store = q_op[2];
        q_size  = q_op[1:0];
    end

    // Next-state logic. The access is latched on accept so the request
    // fields stay stable however long the grant takes. rvalid is only
    // looked at in WAIT, which also makes a post-reset rvalid harmless.
    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        ls_type_d = ls_type_q;
        wdata_d   = wdata_q;
        off_d     = off_q;
        mis_d     = mis_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (mem_valid_M && in_valid) begin
                    waddr_d   = addr_M[31:2];
                    ls_type_d = ls_type_M;
                    wdata_d   = Wdata_M;
                    off_d     = in_off;
                    mis_d     = in_mis;
                    state_d   = in_mis ? DONE : REQ;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    state_d = q_store ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    rdata_d = dmem_rdata >> {off_q, 3'b000};
                    state_d = DONE;
                end
            end
            DONE: begin
                mis_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            waddr_q   <= '0;
            ls_type_q <= '0;
            wdata_q   <= '0;
            off_q     <= '0;
            mis_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            ls_type_q <= ls_type_d;
            wdata_q   <= wdata_d;
            off_q     <= off_d;
            mis_q     <= mis_d;
            rdata_q   <= rdata_d;
        end
    end

    // Outputs. The memory port is only driven in REQ; stall is gated by
    // rst_n so it drops immediately while reset is held.
    always_comb begin
        stall_M    = rst_n && (((state_q == IDLE) && mem_valid_M && in_valid) ||
                               (state_q == REQ) || (state_q == WAIT));
        dmem_req   = (state_q == REQ);
        dmem_addr  = 32'h0;
        dmem_we    = 4'b0000;
        dmem_wdata = 32'h0;
        if (dmem_req) begin
            dmem_addr = {waddr_q, 2'b00};
            if (q_store) begin
                case (q_size)
                    SZ_BYTE: begin
                        dmem_we    = 4'b0001 << off_q;
                        dmem_wdata = {4{wdata_q[7:0]}};
                    end
                    SZ_HALF: begin
                        dmem_we    = 4'b0011 << off_q;
                        dmem_wdata = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        dmem_we    = 4'b1111;
                        dmem_wdata = wdata_q;
                    end
                endcase
            end
        end
        Rdata_M       = rdata_q;
        rdata_valid_M = (state_q == DONE) && !q_store && !mis_q;
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign_M    = (state_q == DONE) && mis_q;
`else
        misalign_M    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_ctrl
//
// Purpose:
//   Directed self-checking bench for dmem_ctrl. Inputs are driven on the
//   falling edge and outputs are checked 1 time unit later, so every check
//   sees the state registered at the previous rising edge.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_dmem_ctrl;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0010;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b1010;
    localparam logic [3:0] OP_SB  = 4'b0001;
    localparam logic [3:0] OP_SH  = 4'b0011;
    localparam logic [3:0] OP_SW  = 4'b0101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid_M;
    logic [3:0]  ls_type_M;
    logic [31:0] addr_M;
    logic [31:0] Wdata_M;
    logic        stall_M;
    logic [31:0] Rdata_M;
    logic        rdata_valid_M;
    logic        misalign_M;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int compared   = 0;
    int mismatched = 0;
    int reqSeen    = 0;

    dmem_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_valid_M  (mem_valid_M),
        .ls_type_M    (ls_type_M),
        .addr_M       (addr_M),
        .Wdata_M      (Wdata_M),
        .stall_M      (stall_M),
        .Rdata_M      (Rdata_M),
        .rdata_valid_M(rdata_valid_M),
        .misalign_M   (misalign_M),
        .dmem_req     (dmem_req),
        .dmem_addr    (dmem_addr),
        .dmem_we      (dmem_we),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata)
    );

    always #5 clk = ~clk;

    // Drive one cycle's worth of inputs on the falling edge, then settle.
    task automatic applyStimulus(input logic rst, input logic mv, input logic [3:0] typ,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic gnt, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        rst_n       = rst;
        mem_valid_M = mv;
        ls_type_M   = typ;
        addr_M      = addr;
        Wdata_M     = wd;
        dmem_gnt    = gnt;
        dmem_rvalid = rv;
        dmem_rdata  = rd;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_valid_M = 1'b0; ls_type_M = 4'h0; addr_M = '0; Wdata_M = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        // Reset held with a valid request present: nothing may stall or issue.
        applyStimulus(0, 1, OP_LW, 32'h0000_1234, 32'h0, 0, 0, 32'h0);
        applyStimulus(0, 1, OP_LW, 32'h0000_1234, 32'h0, 0, 0, 32'h0);
        checkOutput("rst_stall", stall_M, 0);
        checkOutput("rst_req", dmem_req, 0);
        checkOutput("rst_rdata", Rdata_M, 0);
        checkOutput("rst_rvalid", rdata_valid_M, 0);
        checkOutput("rst_mis", misalign_M, 0);
        checkOutput("rst_we", dmem_we, 0);
        checkOutput("rst_addr", dmem_addr, 0);
        checkOutput("rst_wdata", dmem_wdata, 0);

        // LB 0x1003: shifted byte 0xAB, stall cycles 0-2, valid at cycle 3.
        applyStimulus(1, 1, OP_LB, 32'h0000_1003, 32'h0, 0, 0, 32'h0);
        checkOutput("lb_c0_stall", stall_M, 1);
        checkOutput("lb_c0_req", dmem_req, 0);
        applyStimulus(1, 0, OP_LB, 32'h0, 32'h0, 1, 0, 32'h0);
        checkOutput("lb_c1_stall", stall_M, 1);
        checkOutput("lb_c1_req", dmem_req, 1);
        checkOutput("lb_c1_addr", dmem_addr, 32'h0000_1000);
        checkOutput("lb_c1_we", dmem_we, 4'b0000);
        applyStimulus(1, 0, OP_LB, 32'h0, 32'h0, 0, 1, 32'hAB00_0000);
        checkOutput("lb_c2_stall", stall_M, 1);
        checkOutput("lb_c2_req", dmem_req, 0);
        applyStimulus(1, 0, OP_LB, 32'h0, 32'h0, 0, 0, 32'h0);
        checkOutput("lb_c3_rvalid", rdata_valid_M, 1);
        checkOutput("lb_c3_rdata", Rdata_M, 32'h0000_00AB);
        checkOutput("lb_c3_stall", stall_M, 0);
        applyStimulus(1, 0, OP_LB, 32'h0, 32'h0, 0, 1, 32'h5555_5555);
        checkOutput("lb_c4_rvalid", rdata_valid_M, 0);
        checkOutput("lb_c4_stall", stall_M, 0);
        applyStimulus(1, 0, OP_LB, 32'h0, 32'h0, 0, 0, 32'h0);
        checkOutput("lb_hold_rdata", Rdata_M, 32'h0000_00AB);

        // SH 0x2002: upper lanes, replicated halfword, DONE at cycle 2.
        applyStimulus(1, 1, OP_SH, 32'h0000_2002, 32'h0000_BEEF, 0, 0, 32'h0);
        checkOutput("sh_c0_stall", stall_M, 1);
        applyStimulus(1, 0, OP_SH, 32'h0, 32'h0, 1, 0, 32'h0);
        checkOutput("sh_c1_req", dmem_req, 1);
        checkOutput("sh_c1_addr", dmem_addr, 32'h0000_2000);
        checkOutput("sh_c1_we", dmem_we, 4'b1100);
        checkOutput("sh_c1_wdata", dmem_wdata, 32'hBEEF_BEEF);
        applyStimulus(1, 0, OP_SH, 32'h0, 32'h0, 0, 0, 32'h0);
        checkOutput("sh_c2_stall", stall_M, 0);
        checkOutput("sh_c2_req", dmem_req, 0);
        checkOutput("sh_c2_rvalid", rdata_valid_M, 0);
        checkOutput("sh_c2_rdata_hold", Rdata_M, 32'h0000_00AB);

        // SW with grant withheld 5 cycles: request fields frozen.
        applyStimulus(1, 1, OP_SW, 32'h0000_4004, 32'h1234_5678, 0, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, OP_LB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'h0);
            checkOutput("sw_wait_req", dmem_req, 1);
            checkOutput("sw_wait_addr", dmem_addr, 32'h0000_4004);
            checkOutput("sw_wait_we", dmem_we, 4'b1111);
            checkOutput("sw_wait_wdata", dmem_wdata, 32'h1234_5678);
            checkOutput("sw_wait_stall", stall_M, 1);
        end
        applyStimulus(1, 0, OP_LB, 32'h0, 32'h0, 1, 0, 32'h0);
        checkOutput("sw_gnt_req", dmem_req, 1);
        applyStimulus(1, 0, OP_LB, 32'h0, 32'h0, 0, 0, 32'h0);
        checkOutput("sw_done_stall", stall_M, 0);
        checkOutput("sw_done_req", dmem_req, 0);

        // SB at offset 1: lane 1 enable, replicated byte.
        applyStimulus(1, 1, OP_SB, 32'h0000_5001, 32'h0000_00CD, 0, 0, 32'h0);
        applyStimulus(1, 0, OP_SB, 32'h0, 32'h0, 1, 0, 32'h0);
        checkOutput("sb_we", dmem_we, 4'b0010);
        checkOutput("sb_wdata", dmem_wdata, 32'hCDCD_CDCD);
        checkOutput("sb_addr", dmem_addr, 32'h0000_5000);
        applyStimulus(1, 0, OP_SB, 32'h0, 32'h0, 0, 0, 32'h0);

        // LHU 0x6002: upper halfword shifted down by 16.
        applyStimulus(1, 1, OP_LHU, 32'h0000_6002, 32'h0, 0, 0, 32'h0);
        applyStimulus(1, 0, OP_LHU, 32'h0, 32'h0, 1, 0, 32'h0);
        checkOutput("lhu_we", dmem_we, 4'b0000);
        applyStimulus(1, 0, OP_LHU, 32'h0, 32'h0, 0, 1, 32'h1234_ABCD);
        applyStimulus(1, 0, OP_LHU, 32'h0, 32'h0, 0, 0, 32'h0);
        checkOutput("lhu_rdata", Rdata_M, 32'h0000_1234);
        checkOutput("lhu_rvalid", rdata_valid_M, 1);

        // LW 0x3001: trapped, or forced to the aligned word.
`ifdef DMEM_MISALIGN_TRAP_EN
        applyStimulus(1, 1, OP_LW, 32'h0000_3001, 32'h0, 0, 0, 32'h0);
        checkOutput("lwmis_c0_stall", stall_M, 1);
        applyStimulus(1, 0, OP_LW, 32'h0, 32'h0, 1, 0, 32'h0);
        checkOutput("lwmis_c1_req", dmem_req, 0);
        checkOutput("lwmis_c1_mis", misalign_M, 1);
        checkOutput("lwmis_c1_rvalid", rdata_valid_M, 0);
        checkOutput("lwmis_c1_stall", stall_M, 0);
        applyStimulus(1, 0, OP_LW, 32'h0, 32'h0, 0, 0, 32'h0);
        checkOutput("lwmis_c2_mis", misalign_M, 0);
        checkOutput("lwmis_c2_req", dmem_req, 0);
`else
        applyStimulus(1, 1, OP_LW, 32'h0000_3001, 32'h0, 0, 0, 32'h0);
        applyStimulus(1, 0, OP_LW, 32'h0, 32'h0, 1, 0, 32'h0);
        checkOutput("lwmis_req", dmem_req, 1);
        checkOutput("lwmis_addr", dmem_addr, 32'h0000_3000);
        applyStimulus(1, 0, OP_LW, 32'h0, 32'h0, 0, 1, 32'hDEAD_BEEF);
        applyStimulus(1, 0, OP_LW, 32'h0, 32'h0, 0, 0, 32'h0);
        checkOutput("lwmis_rdata", Rdata_M, 32'hDEAD_BEEF);
        checkOutput("lwmis_mis", misalign_M, 0);
`endif

        // Reset while in REQ: request drops on the next cycle.
        applyStimulus(1, 1, OP_SW, 32'h0000_9000, 32'hAAAA_5555, 0, 0, 32'h0);
        applyStimulus(0, 0, OP_LB, 32'h0, 32'h0, 0, 0, 32'h0);
        checkOutput("rstreq_stall", stall_M, 0);
        applyStimulus(1, 0, OP_LB, 32'h0, 32'h0, 1, 0, 32'h0);
        checkOutput("rstreq_req", dmem_req, 0);
        checkOutput("rstreq_we", dmem_we, 0);
        applyStimulus(1, 0, OP_LB, 32'h0, 32'h0, 0, 0, 32'h0);

        // Reset while in WAIT, then a stale rvalid arrives.
        applyStimulus(1, 1, OP_LW, 32'h0000_7000, 32'h0, 0, 0, 32'h0);
        applyStimulus(1, 0, OP_LW, 32'h0, 32'h0, 1, 0, 32'h0);
        applyStimulus(0, 0, OP_LW, 32'h0, 32'h0, 0, 0, 32'h0);
        checkOutput("rstwait_stall", stall_M, 0);
        applyStimulus(1, 0, OP_LW, 32'h0, 32'h0, 0, 1, 32'hFFFF_FFFF);
        checkOutput("rstwait_rdata", Rdata_M, 0);
        checkOutput("rstwait_rvalid", rdata_valid_M, 0);
        checkOutput("rstwait_req", dmem_req, 0);
        checkOutput("rstwait_stall2", stall_M, 0);
        applyStimulus(1, 0, OP_LW, 32'h0, 32'h0, 0, 0, 32'h0);
        checkOutput("rstwait_rvalid2", rdata_valid_M, 0);
        checkOutput("rstwait_rdata2", Rdata_M, 0);

        // mem_valid_M held through DONE: one request only.
        reqSeen = 0;
        applyStimulus(1, 1, OP_LW, 32'h0000_8000, 32'h0, 0, 0, 32'h0);
        reqSeen += int'(dmem_req);
        applyStimulus(1, 1, OP_LW, 32'h0000_8000, 32'h0, 1, 0, 32'h0);
        reqSeen += int'(dmem_req);
        applyStimulus(1, 1, OP_LW, 32'h0000_8000, 32'h0, 0, 1, 32'h1122_3344);
        reqSeen += int'(dmem_req);
        applyStimulus(1, 1, OP_LW, 32'h0000_8000, 32'h0, 0, 0, 32'h0);
        reqSeen += int'(dmem_req);
        checkOutput("hold_done_stall", stall_M, 0);
        checkOutput("hold_done_rvalid", rdata_valid_M, 1);
        checkOutput("hold_done_rdata", Rdata_M, 32'h1122_3344);
        checkOutput("hold_one_req", reqSeen, 1);
        applyStimulus(1, 0, OP_LW, 32'h0, 32'h0, 0, 0, 32'h0);
        checkOutput("hold_idle_stall", stall_M, 0);

        // Nop / invalid codes: no stall, no request.
        applyStimulus(1, 1, 4'b0111, 32'h0000_A000, 32'h0, 0, 0, 32'h0);
        checkOutput("nop_stall", stall_M, 0);
        applyStimulus(1, 1, 4'b1100, 32'h0000_A000, 32'h0, 1, 0, 32'h0);
        checkOutput("nop_req", dmem_req, 0);
        checkOutput("inv_stall", stall_M, 0);
        applyStimulus(1, 0, OP_LH, 32'h0, 32'h0, 0, 0, 32'h0);
        checkOutput("inv_req", dmem_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
